// File: rtl/inst_queue_if.sv
// Fetch/dispatch signal bundle for inst_queue. The slave modport is the queue;
// the master modport drives the fetch and dispatch side.
interface inst_queue_if;
  logic        i_flush;
  logic        i_wr_en;
  logic        i_wr_inst1_vld;
  logic [31:0] i_wr_inst0;
  logic [31:0] i_wr_inst1;
  logic [31:0] i_wr_pc;
  logic        o_wr_rdy;
  logic        o_rd_vld0;
  logic        o_rd_vld1;
  logic [31:0] o_rd_inst0;
  logic [31:0] o_rd_inst1;
  logic [31:0] o_rd_pc0;
  logic [31:0] o_rd_pc1;
  logic        i_rd_en0;
  logic        i_rd_en1;

  modport slave (
    input  i_flush, i_wr_en, i_wr_inst1_vld, i_wr_inst0, i_wr_inst1, i_wr_pc,
    input  i_rd_en0, i_rd_en1,
    output o_wr_rdy, o_rd_vld0, o_rd_vld1, o_rd_inst0, o_rd_inst1, o_rd_pc0, o_rd_pc1
  );

  modport master (
    output i_flush, i_wr_en, i_wr_inst1_vld, i_wr_inst0, i_wr_inst1, i_wr_pc,
    output i_rd_en0, i_rd_en1,
    input  o_wr_rdy, o_rd_vld0, o_rd_vld1, o_rd_inst0, o_rd_inst1, o_rd_pc0, o_rd_pc1
  );
endinterface

// File: rtl/inst_queue.sv
// 2-in/2-out show-ahead instruction queue between fetch and the decoder slots.
// Optional fetch-stall counter o_perf_full_cnt enabled by INST_QUEUE_PERF_EN.
module inst_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
`ifdef INST_QUEUE_PERF_EN
  output logic [31:0] o_perf_full_cnt,
`endif
  inst_queue_if.slave bus
);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      pc_mem_q   [DEPTH];
  logic             wr_rdy, rd_vld0, rd_vld1;
  logic [1:0]       nwr, nrd;

  always_comb begin
    wr_rdy  = (count_q <= (PTR_W+1)'(DEPTH - 2));
    rd_vld0 = (count_q != '0);
    rd_vld1 = (count_q >= (PTR_W+1)'(2));
    head_p1 = head_q + PTR_W'(1);
    tail_p1 = tail_q + PTR_W'(1);

    nwr = '0;
    if (bus.i_wr_en && wr_rdy) nwr = bus.i_wr_inst1_vld ? 2'd2 : 2'd1;
    nrd = 2'(bus.i_rd_en0 & rd_vld0) + 2'(bus.i_rd_en0 & bus.i_rd_en1 & rd_vld1);

    head_d  = head_q + PTR_W'(nrd);
    tail_d  = tail_q + PTR_W'(nwr);
    count_d = count_q + (PTR_W+1)'(nwr) - (PTR_W+1)'(nrd);
    if (bus.i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage has no reset; writes are suppressed when the pointers are being cleared.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !bus.i_flush && (nwr != '0)) begin
      inst_mem_q[tail_q] <= bus.i_wr_inst0;
      pc_mem_q[tail_q]   <= bus.i_wr_pc;
      if (nwr == 2'd2) begin
        inst_mem_q[tail_p1] <= bus.i_wr_inst1;
        pc_mem_q[tail_p1]   <= bus.i_wr_pc + 32'd4;
      end
    end
  end

  assign bus.o_wr_rdy   = wr_rdy;
  assign bus.o_rd_vld0  = rd_vld0;
  assign bus.o_rd_vld1  = rd_vld1;
  assign bus.o_rd_inst0 = inst_mem_q[head_q];
  assign bus.o_rd_pc0   = pc_mem_q[head_q];
  assign bus.o_rd_inst1 = inst_mem_q[head_p1];
  assign bus.o_rd_pc1   = pc_mem_q[head_p1];

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] perf_full_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      perf_full_cnt_q <= '0;
    end else if (bus.i_wr_en && !wr_rdy && (perf_full_cnt_q != '1)) begin
      perf_full_cnt_q <= perf_full_cnt_q + 32'd1;
    end
  end

  assign o_perf_full_cnt = perf_full_cnt_q;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Randomized plus directed bench for inst_queue against a queue-based reference model.
module tb_inst_queue;
  localparam int unsigned DEPTH = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
`ifdef INST_QUEUE_PERF_EN
  logic [31:0] perf_cnt;
`endif

  inst_queue_if bus ();

  inst_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
`ifdef INST_QUEUE_PERF_EN
    .o_perf_full_cnt (perf_cnt),
`endif
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  entry_t      mq[$];
  logic [31:0] m_perf = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int unsigned sz = mq.size();
    chk("vld0", 64'(bus.o_rd_vld0), 64'(sz >= 1));
    chk("vld1", 64'(bus.o_rd_vld1), 64'(sz >= 2));
    chk("wr_rdy", 64'(bus.o_wr_rdy), 64'(sz <= DEPTH - 2));
    if (sz >= 1) begin
      chk("inst0", 64'(bus.o_rd_inst0), 64'(mq[0].inst));
      chk("pc0", 64'(bus.o_rd_pc0), 64'(mq[0].pc));
    end
    if (sz >= 2) begin
      chk("inst1", 64'(bus.o_rd_inst1), 64'(mq[1].inst));
      chk("pc1", 64'(bus.o_rd_pc1), 64'(mq[1].pc));
    end
`ifdef INST_QUEUE_PERF_EN
    chk("perf", 64'(perf_cnt), 64'(m_perf));
`endif
  endtask

  // Reference: apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit rdy;
    int unsigned nrd;
    rdy = (mq.size() <= DEPTH - 2);
    if (i_rst) begin
      mq.delete();
      m_perf = '0;
      return;
    end
    if (bus.i_wr_en && !rdy && m_perf != 32'hFFFF_FFFF) m_perf++;
    if (bus.i_flush) begin
      mq.delete();
      return;
    end
    nrd = 0;
    if (bus.i_rd_en0 && mq.size() >= 1) nrd = 1;
    if (bus.i_rd_en0 && bus.i_rd_en1 && mq.size() >= 2) nrd = 2;
    repeat (nrd) void'(mq.pop_front());
    if (bus.i_wr_en && rdy) begin
      mq.push_back('{inst: bus.i_wr_inst0, pc: bus.i_wr_pc});
      if (bus.i_wr_inst1_vld) mq.push_back('{inst: bus.i_wr_inst1, pc: bus.i_wr_pc + 32'd4});
    end
  endtask

  task automatic drive(input bit rst, input bit fl, input bit we, input bit v1,
                       input bit r0, input bit r1);
    i_rst              = rst;
    bus.i_flush        = fl;
    bus.i_wr_en        = we;
    bus.i_wr_inst1_vld = v1;
    bus.i_wr_inst0     = $urandom();
    bus.i_wr_inst1     = $urandom();
    bus.i_wr_pc        = $urandom() & 32'hFFFF_FFFC;
    bus.i_rd_en0       = r0;
    bus.i_rd_en1       = r1;
    model_edge();
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic idle(); drive(0, 0, 0, 0, 0, 0); endtask
  task automatic do_reset(); drive(1, 0, 0, 0, 0, 0); endtask

  initial begin
    bus.i_flush = 0; bus.i_wr_en = 0; bus.i_wr_inst1_vld = 0;
    bus.i_wr_inst0 = '0; bus.i_wr_inst1 = '0; bus.i_wr_pc = '0;
    bus.i_rd_en0 = 0; bus.i_rd_en1 = 0;
    @(negedge i_clk);

    // Reset state
    do_reset();
    chk("rst_vld0", 64'(bus.o_rd_vld0), 64'd0);
    chk("rst_rdy", 64'(bus.o_wr_rdy), 64'd1);

    // 1: single 2-wide push with fixed data
    i_rst = 0; bus.i_flush = 0; bus.i_rd_en0 = 0; bus.i_rd_en1 = 0;
    bus.i_wr_en = 1; bus.i_wr_inst1_vld = 1;
    bus.i_wr_inst0 = 32'h0000_0013; bus.i_wr_inst1 = 32'h0010_0093; bus.i_wr_pc = 32'h1000;
    model_edge();
    @(posedge i_clk); @(negedge i_clk);
    check_outputs();
    chk("t1_pc0", 64'(bus.o_rd_pc0), 64'h1000);
    chk("t1_pc1", 64'(bus.o_rd_pc1), 64'h1004);
    chk("t1_inst1", 64'(bus.o_rd_inst1), 64'h0010_0093);
    chk("t1_rdy", 64'(bus.o_wr_rdy), 64'd1);

    // 2: fill with 2-wide bundles; the fifth is dropped
    do_reset();
    repeat (3) drive(0, 0, 1, 1, 0, 0);
    chk("t2_rdy6", 64'(bus.o_wr_rdy), 64'd1);
    drive(0, 0, 1, 1, 0, 0);
    chk("t2_rdy8", 64'(bus.o_wr_rdy), 64'd0);
    drive(0, 0, 1, 1, 0, 0);
    chk("t2_vld1", 64'(bus.o_rd_vld1), 64'd1);

    // 3: seven entries block writes; a same-cycle pop does not grant space
    do_reset();
    repeat (7) drive(0, 0, 1, 0, 0, 0);
    chk("t3_rdy7", 64'(bus.o_wr_rdy), 64'd0);
    drive(0, 0, 1, 1, 1, 0);
    chk("t3_rdy6", 64'(bus.o_wr_rdy), 64'd1);

    // 4: push 2 / pop 2 at count 3 with tail wrapping 7 -> 1
    do_reset();
    repeat (7) drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 1, 1, 1, 1);
    chk("t4_vld1", 64'(bus.o_rd_vld1), 64'd1);
    repeat (2) drive(0, 0, 0, 0, 1, 1);

    // 5: flush beats a simultaneous write and read
    do_reset();
    repeat (5) drive(0, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 1, 1);
    chk("t5_vld0", 64'(bus.o_rd_vld0), 64'd0);
    chk("t5_rdy", 64'(bus.o_wr_rdy), 64'd1);

`ifdef INST_QUEUE_PERF_EN
    // 6: stall counter counts blocked pushes and survives flush
    do_reset();
    repeat (4) drive(0, 0, 1, 1, 0, 0);
    repeat (10) drive(0, 0, 1, 1, 0, 0);
    chk("t6_perf", 64'(perf_cnt), 64'd10);
    drive(0, 1, 0, 0, 0, 0);
    chk("t6_perf_fl", 64'(perf_cnt), 64'd10);
`endif

    // Randomized traffic in phases biased toward filling, draining and mixed
    do_reset();
    for (int ph = 0; ph < 24; ph++) begin
      int unsigned wp = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 20 : 55;
      int unsigned rp = (ph % 3 == 0) ? 15 : (ph % 3 == 1) ? 90 : 55;
      for (int c = 0; c < 80; c++) begin
        drive(($urandom_range(0, 399) == 0),
              ($urandom_range(0, 49) == 0),
              ($urandom_range(0, 99) < wp),
              $urandom_range(0, 1) != 0,
              ($urandom_range(0, 99) < rp),
              $urandom_range(0, 2) != 0);
      end
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
